sys_bus_ctrl: RTL

//   Registered, parametrised data-side bus controller between the CPU data port and N memory-mapped slaves
//   (ROM, RAM, UART, further devices). It decodes addr[ADDR_W-1:ADDR_W-4] against a per-slave tag table and

---
 rtl/sys_bus_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sys_bus_ctrl.sv
// sys_bus_ctrl: registered data-side bus controller between the CPU data port
// and NUM_SLV memory-mapped slaves. The top address nibble is decoded against
// a per-slave tag table, and a req/ready handshake runs with the selected
// slave, so a slave may insert wait states. Unmapped addresses and writes to
// read-only slaves complete with an error response. No slave is requested
// for those accesses.
//
// Optional feature: define BUS_TIMEOUT_EN to abort accesses whose slave
// stays silent for TIMEOUT_CYC cycles. These accesses complete with
// err = 1 and rdata = 0.

module sys_bus_ctrl #(
    parameter int                   NUM_SLV     = 3,
    parameter int                   ADDR_W      = 32,
    parameter int                   DATA_W      = 32,
    parameter logic [4*NUM_SLV-1:0] SLV_TAG     = {4'h2, 4'h1, 4'h0},
    parameter logic [NUM_SLV-1:0]   SLV_RO      = 3'b001,
    parameter int                   TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_req,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    input  logic                      cpu_wen,
    output logic                      cpu_ready,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_err,
    output logic [NUM_SLV-1:0]        slv_req,
    output logic [ADDR_W-1:0]         slv_addr,
    output logic [DATA_W-1:0]         slv_wdata,
    output logic                      slv_wen,
    input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]        slv_ready
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t               state;
    logic [SEL_W-1:0]     sel;

    logic                 dec_hit;
    logic                 dec_ro;
    logic [SEL_W-1:0]     dec_idx;
    logic [NUM_SLV-1:0]   dec_onehot;

    logic                 sel_ready;
    logic [DATA_W-1:0]    sel_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]     wait_cnt;
`endif

    // Decode the top address nibble. The loop scans downwards, so the lowest matching index is kept.
    always_comb begin
        dec_hit    = 1'b0;
        dec_ro     = 1'b0;
        dec_idx    = '0;
        dec_onehot = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (cpu_addr[ADDR_W-1 -: 4] == SLV_TAG[4*i +: 4]) begin
                dec_hit       = 1'b1;
                dec_ro        = SLV_RO[i];
                dec_idx       = SEL_W'(i);
                dec_onehot    = '0;
                dec_onehot[i] = 1'b1;
            end
        end
    end

    // Pick the ready bit and read data of the latched slave; other slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_ready = slv_ready[i];
                sel_rdata = slv_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // Access FSM with registered outputs; cpu_rdata/cpu_err hold until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            slv_req   <= '0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            slv_wen   <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        slv_addr  <= cpu_addr;
                        slv_wdata <= cpu_wdata;
                        slv_wen   <= cpu_wen;
                        sel       <= dec_idx;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                        if (dec_hit && !(cpu_wen && dec_ro)) begin
                            slv_req <= dec_onehot;
                            state   <= ACCESS;
                        end else begin
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= '0;
                            state     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        slv_req   <= '0;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b0;
                        cpu_rdata <= slv_wen ? '0 : sel_rdata;
                        state     <= RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        slv_req   <= '0;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
